// File: rtl/regfile_dump.sv
// Generic synchronous FIFO; storage and pointers cleared by reset.
// Latency: push visible at the head one cycle later.
// Backpressure: push ignored when full unless a pop frees a slot in the same cycle.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_vld,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop_rdy,
    output logic                         pop_vld,
    output logic [W-1:0]                 pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_en, pop_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_en  = pop_rdy && (cnt_q != '0);
    assign push_en = push_vld && ((cnt_q != CNT_W'(DEPTH)) || pop_en);

    always_comb begin
        mem_d = mem_q;
        if (push_en) begin
            mem_d[wr_q] = push_dat;
        end
        wr_d  = push_en ? ptr_inc(wr_q) : wr_q;
        rd_d  = pop_en ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign pop_vld = (cnt_q != '0);
    assign pop_dat = mem_q[rd_q];
    assign count   = cnt_q;
endmodule

// Debug register dump: halts fetch, drains the pipeline, streams {addr, data} beats.
// Latency: first read DRAIN_CYCLES+1 cycles after start, beat one cycle after its read.
// Backpressure: reads stall while buffered + in-flight beats would exceed two.
module regfile_dump #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 4,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              halt_req,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data
);
    localparam int CNT_W  = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int BEAT_W = ADDR_W + DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_READ, S_FLUSH} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } beat_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] fl_addr_q, fl_addr_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              rd_en_c;
    logic              pop_c;
    logic [2:0]        occ;
    logic              fifo_vld;
    logic [1:0]        fifo_cnt;
    logic [BEAT_W-1:0] fifo_pop_dat;
    beat_t             fifo_head, ret_beat, head;
    logic              fifo_push, fifo_pop;

    // Returning read bypasses the FIFO when it is empty and the sink takes it at once.
    assign ret_beat   = '{addr: fl_addr_q, data: rd_data};
    assign fifo_head  = fifo_pop_dat;
    assign dump_valid = fifo_vld || inflight_q;
    assign head       = fifo_vld ? fifo_head : ret_beat;
    assign pop_c      = dump_valid && dump_ready;
    assign fifo_pop   = pop_c && fifo_vld;
    assign fifo_push  = inflight_q && !(pop_c && !fifo_vld);

    fifo #(.W(BEAT_W), .DEPTH(2)) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (fifo_push),
        .push_dat (ret_beat),
        .pop_rdy  (fifo_pop),
        .pop_vld  (fifo_vld),
        .pop_dat  (fifo_pop_dat),
        .count    (fifo_cnt)
    );

    // Beats still owed to the sink after this cycle's handshake.
    assign occ = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop_c);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        last_d     = last_q;
        fl_addr_d  = fl_addr_q;
        inflight_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rd_en_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (first_addr <= last_addr) begin
                        addr_d  = first_addr;
                        last_d  = last_addr;
                        cnt_d   = CNT_W'(DRAIN_CYCLES);
                        state_d = S_DRAIN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_READ: begin
                if (occ < 3'd2) begin
                    rd_en_c    = 1'b1;
                    inflight_d = 1'b1;
                    fl_addr_d  = addr_q;
                    if (addr_q == last_q) begin
                        state_d = S_FLUSH;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (occ == 3'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            last_q     <= '0;
            fl_addr_q  <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            fl_addr_q  <= fl_addr_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign halt_req  = busy;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_en     = rd_en_c;
    assign rd_addr   = addr_q;
    assign dump_addr = dump_valid ? head.addr : '0;
    assign dump_data = dump_valid ? head.data : '0;
endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: table-driven dumps, corner sequences, randomized dumps vs range model.
module tb_regfile_dump;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DRAIN  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] first_addr = '0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              busy, halt_req, done, err, rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              dump_valid;
    logic              dump_ready = 1'b0;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;

    regfile_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy), .halt_req(halt_req), .done(done), .err(err), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data)
    );

    always #5 clk = ~clk;

    // Architectural register contents and a one-cycle-latency read port.
    logic [DATA_W-1:0] regs [16];
    always @(posedge clk) if (rd_en) rd_data <= regs[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Observed behaviour, recorded once per cycle away from the active edge.
    int hs_n, rd_n, busy_n, done_n, err_n;
    int hs_first, hs_last, rd_first, vld_first, busy_first, done_cyc, err_cyc, done_busy;
    int halt_bad, full_bad, stab_bad, outstanding;
    bit prev_stall;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_dat;
    logic [ADDR_W-1:0] hs_addr [$];
    logic [DATA_W-1:0] hs_dat [$];

    task automatic clear_rec();
        hs_n = 0; rd_n = 0; busy_n = 0; done_n = 0; err_n = 0;
        hs_first = -1; hs_last = -1; rd_first = -1; vld_first = -1; busy_first = -1;
        done_cyc = -1; err_cyc = -1; done_busy = -1;
        halt_bad = 0; full_bad = 0; stab_bad = 0; outstanding = 0; prev_stall = 0;
        hs_addr.delete(); hs_dat.delete();
    endtask

    always @(negedge clk) begin
        int pop;
        pop = (dump_valid && dump_ready) ? 1 : 0;
        if (halt_req !== busy) halt_bad++;
        if (busy) begin busy_n++; if (busy_first < 0) busy_first = cyc; end
        if (err) begin err_n++; err_cyc = cyc; end
        if (done) begin done_n++; done_cyc = cyc; done_busy = busy; end
        if (prev_stall && (!dump_valid || dump_addr !== p_addr || dump_data !== p_dat)) stab_bad++;
        if (rd_en) begin
            if (outstanding - pop >= 2) full_bad++;
            rd_n++;
            if (rd_first < 0) rd_first = cyc;
        end
        if (dump_valid && vld_first < 0) vld_first = cyc;
        if (pop != 0) begin
            hs_addr.push_back(dump_addr);
            hs_dat.push_back(dump_data);
            hs_n++;
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
        end
        outstanding = outstanding + (rd_en ? 1 : 0) - pop;
        prev_stall = dump_valid && !dump_ready;
        p_addr = dump_addr;
        p_dat = dump_data;
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " halt_req"}, halt_req, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " err"}, err, 0);
        chk({tag, " rd_en"}, rd_en, 0);
        chk({tag, " rd_addr"}, rd_addr, 0);
        chk({tag, " dump_valid"}, dump_valid, 0);
        chk({tag, " dump_addr"}, dump_addr, 0);
        chk({tag, " dump_data"}, dump_data, 0);
    endtask

    // mode 0: ready high; 1: toggling with a 10-cycle stall; 2: random ready.
    task automatic run_dump(input int f, input int l, input int mode, input bit mid,
                            input int exp_err, input int exp_beats, input string tag);
        int s_cyc, k;
        bit fin;
        clear_rec();
        @(posedge clk); #1;
        start = 1'b1; first_addr = 4'(f); last_addr = 4'(l); s_cyc = cyc;
        dump_ready = (mode == 0);
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; fin = 0;
        while (k < 400 && !fin) begin
            case (mode)
                0: dump_ready = 1'b1;
                1: dump_ready = (k >= 10 && k < 20) ? 1'b0 : (k % 2 == 0);
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
            if (mid && k == 12) begin
                start = 1'b1; first_addr = '0; last_addr = '0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
            fin = (exp_err != 0) ? (k >= 12) : (done_n > 0);
        end
        start = 1'b0;
        chk({tag, " finished in budget"}, fin, 1);
        dump_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        chk({tag, " err pulses"}, err_n, exp_err);
        chk({tag, " beats"}, hs_n, exp_beats);
        for (int j = 0; j < hs_n; j++) begin
            if (j < exp_beats)
                chk($sformatf("%s beat%0d", tag, j), {hs_addr[j], hs_dat[j]}, {4'(f + j), regs[f + j]});
        end
        chk({tag, " done pulses"}, done_n, (exp_err != 0) ? 0 : 1);
        chk({tag, " halt_req==busy"}, halt_bad, 0);
        chk({tag, " read with buffer full"}, full_bad, 0);
        chk({tag, " stall stability"}, stab_bad, 0);
        if (exp_err != 0) begin
            chk({tag, " err cycle"}, err_cyc, s_cyc + 1);
            chk({tag, " busy cycles"}, busy_n, 0);
            chk({tag, " reads"}, rd_n, 0);
        end else begin
            chk({tag, " busy rise"}, busy_first, s_cyc + 1);
            chk({tag, " done after last beat"}, done_cyc, hs_last + 1);
            chk({tag, " busy at done"}, done_busy, 0);
            if (mode == 0) begin
                chk({tag, " first rd_en"}, rd_first, s_cyc + DRAIN + 2);
                chk({tag, " first valid"}, vld_first, s_cyc + DRAIN + 3);
                chk({tag, " no bubbles"}, hs_last - hs_first, exp_beats - 1);
            end
        end
    endtask

    typedef struct {
        int          first;
        int          last;
        int          mode;
        bit          mid;
        int          exp_err;
        int          exp_beats;
        logic [31:0] exp_first_dat;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int f, l, t, k;
        tbl[0] = '{0, 15, 0, 1'b0, 0, 16, 32'h100};
        tbl[1] = '{0, 15, 1, 1'b0, 0, 16, 32'h100};
        tbl[2] = '{9, 2, 0, 1'b0, 1, 0, 32'h0};
        tbl[3] = '{15, 15, 1, 1'b0, 0, 1, 32'h10F};
        tbl[4] = '{0, 15, 0, 1'b1, 0, 16, 32'h100};
        tbl[5] = '{13, 15, 1, 1'b0, 0, 3, 32'h10D};
        for (int r = 0; r < 16; r++) regs[r] = 32'h100 + r;
        clear_rec();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_dump(tbl[i].first, tbl[i].last, tbl[i].mode, tbl[i].mid,
                     tbl[i].exp_err, tbl[i].exp_beats, $sformatf("vec%0d", i));
            if (tbl[i].exp_beats > 0 && hs_n > 0)
                chk($sformatf("vec%0d first data", i), hs_dat[0], tbl[i].exp_first_dat);
        end

        regs[3] = 32'hDEAD_BEEF;
        run_dump(3, 3, 0, 1'b0, 0, 1, "single");
        if (hs_n > 0) chk("single data", hs_dat[0], 32'hDEAD_BEEF);

        // Reset in the middle of a dump, then a clean follow-up dump.
        clear_rec();
        @(posedge clk); #1;
        start = 1'b1; first_addr = 4'd0; last_addr = 4'd15; dump_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (hs_n < 5 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst_mid reached 5 beats", hs_n >= 5, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        run_dump(12, 15, 0, 1'b0, 0, 4, "after_rst");

        for (int it = 0; it < 20; it++) begin
            for (int r = 0; r < 16; r++) regs[r] = $urandom;
            f = $urandom_range(0, 15);
            l = $urandom_range(0, 15);
            if (f > l && $urandom_range(0, 3) != 0) begin t = f; f = l; l = t; end
            run_dump(f, l, 2, 1'b0, (f > l) ? 1 : 0, (f > l) ? 0 : (l - f + 1),
                     $sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
